riscv_dmem_responder: RTL

//  Responder end of the core's data-memory val/rdy request/response interface.

---
 rtl/riscv_mem_pkg.sv | 60 ++++++
 rtl/riscv_dmem_resp_queue.sv | 98 +++++++++
 rtl/riscv_dmem_responder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared encodings, response message layout and byte-lane helpers for the
// data-memory request/response interface.
package riscv_mem_pkg;

  localparam logic       MEMREQ_READ  = 1'b0;
  localparam logic       MEMREQ_WRITE = 1'b1;

  localparam logic [1:0] MEMLEN_WORD  = 2'd0;
  localparam logic [1:0] MEMLEN_BYTE  = 2'd1;
  localparam logic [1:0] MEMLEN_HALF  = 2'd2;

  typedef struct packed {
    logic        msg_type;
    logic [1:0]  len;
    logic [31:0] data;
  } memresp_msg_t;

  // Byte lanes touched by an access; reserved len behaves as a word.
  function automatic logic [3:0] byte_enable(input logic [1:0] len, input logic [1:0] off);
    logic [3:0] be;
    case (len)
      MEMLEN_BYTE: be = 4'b0001 << off;
      MEMLEN_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [31:0] data, input logic [1:0] len);
    logic [31:0] lanes;
    case (len)
      MEMLEN_BYTE: lanes = {4{data[7:0]}};
      MEMLEN_HALF: lanes = {2{data[15:0]}};
      default:     lanes = data;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] align_load(input logic [31:0] word, input logic [1:0] len,
                                             input logic [1:0] off);
    logic [31:0] sh;
    logic [31:0] res;
    case (len)
      MEMLEN_BYTE: begin
        sh  = word >> {off, 3'b000};
        res = {24'h000000, sh[7:0]};
      end
      MEMLEN_HALF: begin
        sh  = word >> {off[1], 4'b0000};
        res = {16'h0000, sh[15:0]};
      end
      default: begin
        sh  = word;
        res = sh;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/riscv_dmem_resp_queue.sv
// Response FIFO with a registered head. The enqueue side has no ready: the
// upstream credit counter never issues more entries than DEPTH.
import riscv_mem_pkg::*;

module riscv_dmem_resp_queue #(
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enq_val,
  input  memresp_msg_t enq_msg,
  output logic         deq_val,
  input  logic         deq_rdy,
  output memresp_msg_t deq_msg
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  memresp_msg_t     buf_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] rd_ptr_n_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_n_s;
  logic [CNT_W-1:0] remain_s;
  logic             val_r;
  memresp_msg_t     msg_r;
  memresp_msg_t     head_s;
  logic             enq_fire_s;
  logic             deq_fire_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(DEPTH - 1)) n = PTR_W'(0);
    else                        n = p + PTR_W'(1);
    return n;
  endfunction

  assign enq_fire_s = enq_val && (count_r != CNT_W'(DEPTH));
  assign deq_fire_s = val_r && deq_rdy;
  assign deq_val    = val_r;
  assign deq_msg    = msg_r;

  // Next occupancy and next head; an enqueue into an otherwise empty queue bypasses storage.
  always_comb begin
    count_n_s  = count_r;
    remain_s   = count_r;
    rd_ptr_n_s = rd_ptr_r;
    head_s     = msg_r;
    case ({enq_fire_s, deq_fire_s})
      2'b10:   count_n_s = count_r + CNT_W'(1);
      2'b01:   count_n_s = count_r - CNT_W'(1);
      default: count_n_s = count_r;
    endcase
    if (deq_fire_s) begin
      remain_s   = count_r - CNT_W'(1);
      rd_ptr_n_s = next_ptr(rd_ptr_r);
    end else begin
      remain_s   = count_r;
      rd_ptr_n_s = rd_ptr_r;
    end
    if (count_n_s == CNT_W'(0)) begin
      head_s = msg_r;
    end else if (remain_s == CNT_W'(0)) begin
      head_s = enq_msg;
    end else begin
      head_s = buf_r[rd_ptr_n_s];
    end
  end

  // Entry storage, not reset.
  always_ff @(posedge clk) begin
    if (enq_fire_s) begin
      buf_r[wr_ptr_r] <= enq_msg;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      val_r    <= 1'b0;
      msg_r    <= '{msg_type: 1'b0, len: 2'b00, data: 32'h0000_0000};
    end else begin
      if (enq_fire_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      rd_ptr_r <= rd_ptr_n_s;
      count_r  <= count_n_s;
      val_r    <= (count_n_s != CNT_W'(0));
      msg_r    <= head_s;
    end
  end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: word array with byte-lane writes, fixed-latency
// in-order responses and credit-based request flow control.
import riscv_mem_pkg::*;

module riscv_dmem_responder #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE = 32'h0008_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  input  logic        memreq_msg_type,
  input  logic [31:0] memreq_msg_addr,
  input  logic [1:0]  memreq_msg_len,
  input  logic [31:0] memreq_msg_data,
  output logic        memresp_val,
  input  logic        memresp_rdy,
  output logic        memresp_msg_type,
  output logic [1:0]  memresp_msg_len,
  output logic [31:0] memresp_msg_data
);

  localparam int DEPTH = LATENCY + 1;
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      mem_r [MEM_WORDS];
  logic [CNT_W-1:0] cnt_r;
  logic             req_fire_s;
  logic             resp_fire_s;
  logic [IDX_W-1:0] idx_s;
  logic [1:0]       off_s;
  logic [3:0]       wr_be_s;
  logic [31:0]      wr_data_s;
  logic [31:0]      rd_word_s;
  memresp_msg_t     req_msg_s;
  memresp_msg_t     enq_msg_s;
  memresp_msg_t     q_msg_s;
  logic             enq_val_s;
  logic             q_val_s;

  // Ready depends only on reset and the credit count, never on memresp_rdy.
  assign memreq_rdy  = !reset && (cnt_r < CNT_W'(DEPTH));
  assign req_fire_s  = memreq_val && memreq_rdy;
  assign resp_fire_s = q_val_s && memresp_rdy;
  assign idx_s       = IDX_W'((memreq_msg_addr - ADDR_BASE) >> 2);
  assign off_s       = memreq_msg_addr[1:0];

  // Lane selection and accept-cycle read of the addressed word.
  always_comb begin
    wr_be_s            = byte_enable(memreq_msg_len, off_s);
    wr_data_s          = store_lanes(memreq_msg_data, memreq_msg_len);
    rd_word_s          = mem_r[idx_s];
    req_msg_s.msg_type = memreq_msg_type;
    req_msg_s.len      = memreq_msg_len;
    if (memreq_msg_type == MEMREQ_WRITE) begin
      req_msg_s.data = 32'h0000_0000;
    end else begin
      req_msg_s.data = align_load(rd_word_s, memreq_msg_len, off_s);
    end
  end

  // Byte-lane array update; contents survive reset.
  always_ff @(posedge clk) begin
    if (req_fire_s && (memreq_msg_type == MEMREQ_WRITE)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_s[b]) begin
          mem_r[idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
        end
      end
    end
  end

  // Credits: accepted transactions not yet dequeued by the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= CNT_W'(0);
    end else begin
      case ({req_fire_s, resp_fire_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  generate
    if (LATENCY == 1) begin : g_no_delay
      assign enq_val_s = req_fire_s;
      assign enq_msg_s = req_msg_s;
    end else begin : g_delay
      logic         dly_val_r [LATENCY-1];
      memresp_msg_t dly_msg_r [LATENCY-1];

      // Fixed delay line between accept and the response queue.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < LATENCY - 1; i++) begin
            dly_val_r[i] <= 1'b0;
          end
        end else begin
          dly_val_r[0] <= req_fire_s;
          for (int i = 1; i < LATENCY - 1; i++) begin
            dly_val_r[i] <= dly_val_r[i-1];
          end
        end
        dly_msg_r[0] <= req_msg_s;
        for (int i = 1; i < LATENCY - 1; i++) begin
          dly_msg_r[i] <= dly_msg_r[i-1];
        end
      end

      assign enq_val_s = dly_val_r[LATENCY-2];
      assign enq_msg_s = dly_msg_r[LATENCY-2];
    end
  endgenerate

  riscv_dmem_resp_queue #(
    .DEPTH (DEPTH)
  ) u_resp_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq_val_s),
    .enq_msg (enq_msg_s),
    .deq_val (q_val_s),
    .deq_rdy (memresp_rdy),
    .deq_msg (q_msg_s)
  );

  assign memresp_val      = q_val_s;
  assign memresp_msg_type = q_msg_s.msg_type;
  assign memresp_msg_len  = q_msg_s.len;
  assign memresp_msg_data = q_msg_s.data;

endmodule
